// File: rtl/instr_fetch_if.sv
// Signal bundle between the fetch stage, its instruction memory and decode.
// The master modport is the fetch stage; the slave modport is its environment.
interface instr_fetch_if;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_en;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic [31:0] instruction;
  logic [31:0] pc;
  logic        valid;

  modport master (
    input  stall, redirect_valid, redirect_pc, imem_rdata,
    output imem_en, imem_addr, instruction, pc, valid
  );

  modport slave (
    output stall, redirect_valid, redirect_pc, imem_rdata,
    input  imem_en, imem_addr, instruction, pc, valid
  );
endinterface

// File: rtl/instr_fetch.sv
// IF stage with IF/ID register: drives a 1-cycle-latency instruction memory and
// keeps one stalled response in a skid entry so no fetched word is ever lost.
module instr_fetch #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic          clk,
  input  logic          reset,
  instr_fetch_if.master bus
);

  typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q;
  logic        rsp_valid_q;
  logic [31:0] rsp_pc_q;
  logic        skid_valid_q;
  logic [31:0] skid_instr_q;
  logic [31:0] skid_pc_q;
  logic        id_valid_q;
  logic [31:0] id_instr_q;
  logic [31:0] id_pc_q;

  logic        issue;
  logic        flush;
  logic        load_rsp;
  logic        load_skid;
  logic        capture_skid;
  logic [31:0] redirect_aligned;

  assign redirect_aligned = bus.redirect_pc & 32'hFFFF_FFFC;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (bus.redirect_valid) begin
      state_d = RUN;
    end else begin
      case (state_q)
        IDLE:    state_d = RUN;
        RUN:     if (bus.stall && rsp_valid_q) state_d = HOLD;
        HOLD:    if (!bus.stall) state_d = RUN;
        default: state_d = IDLE;
      endcase
    end
  end

  // A redirect overrides every other action, including a stall.
  always_comb begin
    issue        = (state_q != IDLE) && !bus.stall && !bus.redirect_valid;
    flush        = bus.redirect_valid;
    load_rsp     = 1'b0;
    load_skid    = 1'b0;
    capture_skid = 1'b0;
    if (!bus.redirect_valid) begin
      case (state_q)
        IDLE: load_rsp = !bus.stall;
        RUN: begin
          load_rsp     = !bus.stall;
          capture_skid = bus.stall && rsp_valid_q;
        end
        HOLD:    load_skid = !bus.stall && skid_valid_q;
        default: load_rsp = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q         <= RESET_PC;
      rsp_valid_q  <= 1'b0;
      rsp_pc_q     <= RESET_PC;
      skid_valid_q <= 1'b0;
      skid_instr_q <= NOP_INSTR;
      skid_pc_q    <= RESET_PC;
      id_valid_q   <= 1'b0;
      id_instr_q   <= NOP_INSTR;
      id_pc_q      <= RESET_PC;
    end else begin
      rsp_valid_q <= issue;
      if (issue) begin
        pc_q     <= pc_q + 32'd4;
        rsp_pc_q <= pc_q;
      end
      if (flush) begin
        pc_q         <= redirect_aligned;
        id_valid_q   <= 1'b0;
        id_instr_q   <= NOP_INSTR;
        skid_valid_q <= 1'b0;
      end
      if (load_rsp) begin
        id_valid_q <= rsp_valid_q;
        id_instr_q <= rsp_valid_q ? bus.imem_rdata : NOP_INSTR;
        id_pc_q    <= rsp_pc_q;
      end
      if (load_skid) begin
        id_valid_q   <= 1'b1;
        id_instr_q   <= skid_instr_q;
        id_pc_q      <= skid_pc_q;
        skid_valid_q <= 1'b0;
      end
      // The memory word is only on the bus for one cycle, so park it while decode is stalled.
      if (capture_skid) begin
        skid_instr_q <= bus.imem_rdata;
        skid_pc_q    <= rsp_pc_q;
        skid_valid_q <= 1'b1;
      end
    end
  end

  assign bus.imem_en     = issue;
  assign bus.imem_addr   = pc_q;
  assign bus.instruction = id_instr_q;
  assign bus.pc          = id_pc_q;
  assign bus.valid       = id_valid_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: directed scenarios with literal expectations,
// then randomized stall/redirect/reset traffic checked against a queue-based model.
module tb_instr_fetch;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic clk;
  logic reset;
  int   n_vec;
  int   n_err;
  bit   chk_on;
  bit   verbose;

  instr_fetch_if bus ();

  instr_fetch #(
    .RESET_PC (32'h0000_0000),
    .NOP_INSTR(NOP)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hA500_0000;
  endfunction

  // Synchronous memory: word is returned the cycle after the request.
  always @(posedge clk) begin
    if (bus.imem_en) bus.imem_rdata <= mem_word(bus.imem_addr);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: fetched words that came back from memory wait in a queue
  // until decode takes them; a redirect or reset empties everything.
  logic [31:0] q_pc[$];
  bit          m_started = 1'b0;
  bit          m_valid = 1'b0;
  logic [31:0] m_pc = 32'h0;
  logic [31:0] m_next = 32'h0;
  bit          m_inflight = 1'b0;
  logic [31:0] m_inflight_pc = 32'h0;

  always @(negedge clk) begin
    bit en_exp;
    en_exp = m_started && !bus.stall && !bus.redirect_valid;
    if (chk_on) begin
      check("imem_en", {31'd0, bus.imem_en}, {31'd0, en_exp});
      if (en_exp) check("imem_addr", bus.imem_addr, m_next);
      check("valid", {31'd0, bus.valid}, {31'd0, m_valid});
      check("instruction", bus.instruction, m_valid ? mem_word(m_pc) : NOP);
      if (m_valid) check("pc", bus.pc, m_pc);
      if (verbose && bus.valid) $display("deliver pc=%h instr=%h", bus.pc, bus.instruction);
    end
    // advance the model to the state after the coming rising edge
    if (reset) begin
      q_pc.delete();
      m_inflight = 1'b0;
      m_valid    = 1'b0;
      m_pc       = 32'h0;
      m_next     = 32'h0;
      m_started  = 1'b0;
    end else if (bus.redirect_valid) begin
      q_pc.delete();
      m_inflight = 1'b0;
      m_valid    = 1'b0;
      m_next     = {bus.redirect_pc[31:2], 2'b00};
      m_started  = 1'b1;
    end else begin
      if (m_inflight) q_pc.push_back(m_inflight_pc);
      m_inflight = en_exp;
      if (en_exp) begin
        m_inflight_pc = m_next;
        m_next        = m_next + 32'd4;
      end
      if (!bus.stall) begin
        if (q_pc.size() != 0) begin
          m_valid = 1'b1;
          m_pc    = q_pc.pop_front();
        end else begin
          m_valid = 1'b0;
        end
      end
      m_started = 1'b1;
    end
  end

  task automatic cyc(input bit r, input bit s, input bit rv, input logic [31:0] rpc);
    @(posedge clk);
    #1;
    reset              = r;
    bus.stall          = s;
    bus.redirect_valid = rv;
    bus.redirect_pc    = rpc;
    @(negedge clk);
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    chk_on = 1'b0;
    verbose = 1'b1;
    reset = 1'b1;
    bus.stall = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc = 32'h0;
    bus.imem_rdata = 32'h0;

    cyc(1, 0, 0, 32'h0);
    chk_on = 1'b1;
    cyc(1, 0, 0, 32'h0);
    check("rst_valid", {31'd0, bus.valid}, 32'd0);
    check("rst_instr", bus.instruction, 32'h13);
    check("rst_pc", bus.pc, 32'h0);
    check("rst_en", {31'd0, bus.imem_en}, 32'd0);

    // reset release: one idle cycle, then one fetch per cycle
    cyc(0, 0, 0, 32'h0);  check("idle_en", {31'd0, bus.imem_en}, 32'd0);
    cyc(0, 0, 0, 32'h0);  check("req0_en", {31'd0, bus.imem_en}, 32'd1);
                          check("req0_addr", bus.imem_addr, 32'h0);
    cyc(0, 0, 0, 32'h0);  check("lat_valid", {31'd0, bus.valid}, 32'd0);
                          check("req1_addr", bus.imem_addr, 32'h4);
    cyc(0, 0, 0, 32'h0);  check("first_valid", {31'd0, bus.valid}, 32'd1);
                          check("first_pc", bus.pc, 32'h0);
                          check("first_instr", bus.instruction, 32'hA500_0000);
    cyc(0, 0, 0, 32'h0);  check("second_pc", bus.pc, 32'h4);

    // three stall cycles with pc=8 in IF/ID
    for (int i = 0; i < 3; i++) begin
      cyc(0, 1, 0, 32'h0);
      check("stall_hold_pc", bus.pc, 32'h8);
      check("stall_no_req", {31'd0, bus.imem_en}, 32'd0);
    end
    cyc(0, 0, 0, 32'h0);  check("release_pc", bus.pc, 32'h8);
                          check("release_addr", bus.imem_addr, 32'h10);
    cyc(0, 0, 0, 32'h0);  check("skid_pc", bus.pc, 32'hC);
    cyc(0, 0, 0, 32'h0);  check("after_skid_pc", bus.pc, 32'h10);

    // redirect to 0x100
    cyc(0, 0, 1, 32'h100); check("redir_no_req", {31'd0, bus.imem_en}, 32'd0);
    cyc(0, 0, 0, 32'h0);   check("redir_flush_valid", {31'd0, bus.valid}, 32'd0);
                           check("redir_flush_instr", bus.instruction, 32'h13);
                           check("redir_target_addr", bus.imem_addr, 32'h100);
    cyc(0, 0, 0, 32'h0);   check("redir_gap", {31'd0, bus.valid}, 32'd0);
    cyc(0, 0, 0, 32'h0);   check("redir_valid", {31'd0, bus.valid}, 32'd1);
                           check("redir_pc", bus.pc, 32'h100);

    // fill skid, then redirect+stall together
    cyc(0, 1, 0, 32'h0);   check("skid_fill_pc", bus.pc, 32'h104);
    cyc(0, 1, 1, 32'h40);
    cyc(0, 1, 0, 32'h0);   check("rs_flush_valid", {31'd0, bus.valid}, 32'd0);
                           check("rs_flush_instr", bus.instruction, 32'h13);
    cyc(0, 1, 0, 32'h0);   check("rs_stalled_valid", {31'd0, bus.valid}, 32'd0);
    cyc(0, 0, 0, 32'h0);   check("rs_addr", bus.imem_addr, 32'h40);
    cyc(0, 0, 0, 32'h0);
    cyc(0, 0, 0, 32'h0);   check("rs_pc", bus.pc, 32'h40);

    // misaligned target and address wrap
    cyc(0, 0, 1, 32'h103);
    cyc(0, 0, 0, 32'h0);   check("align_addr", bus.imem_addr, 32'h100);
    cyc(0, 0, 1, 32'hFFFF_FFFC);
    cyc(0, 0, 0, 32'h0);   check("wrap_addr_hi", bus.imem_addr, 32'hFFFF_FFFC);
    cyc(0, 0, 0, 32'h0);   check("wrap_addr_lo", bus.imem_addr, 32'h0);
    cyc(0, 0, 0, 32'h0);   check("wrap_pc_hi", bus.pc, 32'hFFFF_FFFC);
    cyc(0, 0, 0, 32'h0);   check("wrap_pc_lo", bus.pc, 32'h0);

    // reset while holding a skid entry
    cyc(0, 1, 0, 32'h0);
    cyc(0, 1, 0, 32'h0);
    cyc(1, 1, 0, 32'h0);
    cyc(0, 0, 0, 32'h0);   check("hold_rst_valid", {31'd0, bus.valid}, 32'd0);
                           check("hold_rst_en", {31'd0, bus.imem_en}, 32'd0);
    cyc(0, 0, 0, 32'h0);   check("hold_rst_addr", bus.imem_addr, 32'h0);
    cyc(0, 0, 0, 32'h0);
    cyc(0, 0, 0, 32'h0);   check("hold_rst_pc", bus.pc, 32'h0);

    // randomized traffic, checked every cycle by the model
    verbose = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      bit          r, s, rv;
      logic [31:0] rpc;
      r   = ($urandom_range(0, 199) == 0);
      rv  = ($urandom_range(0, 19) == 0);
      s   = ($urandom_range(0, 9) < 3);
      rpc = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF)) : $urandom;
      cyc(r, s, rv, rpc);
    end
    cyc(0, 0, 0, 32'h0);
    cyc(0, 0, 0, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
